// File: rtl/display_panel_pkg.sv
// Shared definitions for the LED panel receiver: colour indices, output
// stream states and the packing rule for per-pixel count fields.
package display_panel_pkg;

  localparam int unsigned COLOUR_R = 0;
  localparam int unsigned COLOUR_G = 1;
  localparam int unsigned COLOUR_B = 2;
  localparam int unsigned COLOURS  = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } out_state_e;

  // Bit offset of the (segment, colour) count inside one output word.
  function automatic int unsigned field_offset(input int unsigned segment,
                                               input int unsigned colour,
                                               input int unsigned countwidth);
    return (COLOURS * segment + colour) * countwidth;
  endfunction

endpackage

// File: rtl/display_panel_accumulator.sv
// Panel latch register plus one saturating on-time counter per pixel bit.
// count_next_o carries this cycle's increment so a row handoff can copy it.
module display_panel_accumulator
  import display_panel_pkg::*;
#(
  parameter int unsigned COLUMNS    = 32,
  parameter int unsigned NBITS      = 3,
  parameter int unsigned COUNTWIDTH = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          latch_en_i,
  input  logic [COLUMNS-1:0][NBITS-1:0]                 shift_i,
  input  logic                                          count_en_i,
  input  logic                                          clear_i,
  output logic [COLUMNS-1:0][NBITS-1:0][COUNTWIDTH-1:0] count_next_o
);

  logic [COLUMNS-1:0][NBITS-1:0]                 latch_q;
  logic [COLUMNS-1:0][NBITS-1:0][COUNTWIDTH-1:0] count_q;
  logic [COLUMNS-1:0][NBITS-1:0][COUNTWIDTH-1:0] count_d;

  // Increment uses the latch contents from before any same-cycle latch.
  always_comb begin
    count_next_o = count_q;
    for (int unsigned c = 0; c < COLUMNS; c++) begin
      for (int unsigned b = 0; b < NBITS; b++) begin
        if (count_en_i && latch_q[c][b] && (count_q[c][b] != '1)) begin
          count_next_o[c][b] = count_q[c][b] + COUNTWIDTH'(1);
        end
      end
    end
  end

  assign count_d = clear_i ? '0 : count_next_o;

  always_ff @(posedge clk) begin
    if (!rst) begin
      latch_q <= '0;
      count_q <= '0;
    end else begin
      if (latch_en_i) begin
        latch_q <= shift_i;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/display_panel_receiver.sv
// LED panel model: registers the serial panel interface, shifts and latches
// pixel data, integrates on-time per pixel and streams each finished row.
module display_panel_receiver
  import display_panel_pkg::*;
#(
  parameter  int unsigned SEGMENTS   = 1,
  parameter  int unsigned ROWS       = 8,
  parameter  int unsigned COLUMNS    = 32,
  parameter  int unsigned COUNTWIDTH = 16,
  localparam int unsigned NBITS      = COLOURS * SEGMENTS,
  localparam int unsigned ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W      = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NBITS-1:0]            rgb,
  input  logic                        oclk,
  input  logic                        lat,
  input  logic                        oe,
  input  logic [ROW_W-1:0]            row,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROW_W-1:0]            out_row,
  output logic [COL_W-1:0]            out_column,
  output logic [NBITS*COUNTWIDTH-1:0] out_count,
  output logic                        overflow
);

  logic [NBITS-1:0] rgb_q;
  logic             oclk_q, lat_q, oe_q;
  logic             oclk_prev_q, lat_prev_q;
  logic [ROW_W-1:0] row_q;

  logic [COLUMNS-1:0][NBITS-1:0] shift_q, shift_d;
  logic [ROW_W-1:0]              latched_row_q;
  logic                          row_valid_q;

  out_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] buf_row_q;
  logic             overflow_q;
  logic [COLUMNS-1:0][NBITS-1:0][COUNTWIDTH-1:0] buf_q, count_next;

  logic oclk_rise, lat_rise, handoff, load, drop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_q       <= '0;
      oclk_q      <= 1'b0;
      lat_q       <= 1'b0;
      oe_q        <= 1'b0;
      row_q       <= '0;
      oclk_prev_q <= 1'b0;
      lat_prev_q  <= 1'b0;
    end else begin
      rgb_q       <= rgb;
      oclk_q      <= oclk;
      lat_q       <= lat;
      oe_q        <= oe;
      row_q       <= row;
      oclk_prev_q <= oclk_q;
      lat_prev_q  <= lat_q;
    end
  end

  assign oclk_rise = oclk_q && !oclk_prev_q;
  assign lat_rise  = lat_q && !lat_prev_q;
  assign handoff   = lat_rise && row_valid_q && (row_q != latched_row_q);

  always_comb begin
    shift_d = shift_q;
    if (oclk_rise) begin
      for (int unsigned c = 0; c < COLUMNS - 1; c++) begin
        shift_d[c] = shift_q[c + 1];
      end
      shift_d[COLUMNS-1] = rgb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q       <= '0;
      latched_row_q <= '0;
      row_valid_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      if (lat_rise) begin
        latched_row_q <= row_q;
        row_valid_q   <= 1'b1;
      end
    end
  end

  display_panel_accumulator #(
    .COLUMNS   (COLUMNS),
    .NBITS     (NBITS),
    .COUNTWIDTH(COUNTWIDTH)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .latch_en_i  (lat_rise),
    .shift_i     (shift_q),
    .count_en_i  (oe_q && row_valid_q),
    .clear_i     (handoff),
    .count_next_o(count_next)
  );

  // A handoff while streaming is dropped, even on the final word's accept.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handoff) begin
          load    = 1'b1;
          state_d = ST_STREAM;
          col_d   = '0;
        end
      end
      ST_STREAM: begin
        drop = handoff;
        if (out_ready) begin
          if (col_q == COL_W'(COLUMNS - 1)) begin
            state_d = ST_IDLE;
            col_d   = '0;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      buf_q      <= '0;
      buf_row_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      overflow_q <= drop;
      if (load) begin
        buf_q     <= count_next;
        buf_row_q <= latched_row_q;
      end
    end
  end

  assign out_valid  = (state_q == ST_STREAM);
  assign out_row    = buf_row_q;
  assign out_column = col_q;
  assign overflow   = overflow_q;

  always_comb begin
    out_count = '0;
    for (int unsigned s = 0; s < SEGMENTS; s++) begin
      out_count[field_offset(s, COLOUR_R, COUNTWIDTH) +: COUNTWIDTH] =
        buf_q[col_q][COLOURS * s + COLOUR_R];
      out_count[field_offset(s, COLOUR_G, COUNTWIDTH) +: COUNTWIDTH] =
        buf_q[col_q][COLOURS * s + COLOUR_G];
      out_count[field_offset(s, COLOUR_B, COUNTWIDTH) +: COUNTWIDTH] =
        buf_q[col_q][COLOURS * s + COLOUR_B];
    end
  end

endmodule

// File: tb/tb_display_panel_receiver.sv
// Bench for display_panel_receiver: directed panel scenarios plus random
// traffic, all checked cycle by cycle against a pixel-level reference model.
module tb_display_panel_receiver;

  localparam int unsigned SEG  = 2;
  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned NB   = 3 * SEG;
  localparam int unsigned MAXC = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NB-1:0]    rgb = '0;
  logic             oclk = 1'b0, lat = 1'b0, oe = 1'b0;
  logic [1:0]       row = '0;
  logic             out_valid, out_ready = 1'b0;
  logic [1:0]       out_row, out_column;
  logic [NB*CW-1:0] out_count;
  logic             overflow;

  always #5 clk = ~clk;

  display_panel_receiver #(
    .SEGMENTS  (SEG),
    .ROWS      (ROWS),
    .COLUMNS   (COLS),
    .COUNTWIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rgb       (rgb),
    .oclk      (oclk),
    .lat       (lat),
    .oe        (oe),
    .row       (row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_column(out_column),
    .out_count (out_count),
    .overflow  (overflow)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: panel state as plain arrays, stream as words-remaining.
  typedef struct {
    bit [NB-1:0] rgb;
    bit          oclk;
    bit          lat;
    bit          oe;
    int unsigned row;
  } sample_t;

  bit [NB-1:0] m_shift [COLS];
  bit [NB-1:0] m_latch [COLS];
  int unsigned m_acc   [COLS][NB];
  int unsigned m_word  [COLS][NB];
  int unsigned m_lrow, m_wrow, m_left;
  bit          m_rvalid, m_ovf;
  sample_t     m_pend, m_prev;

  logic [NB*CW-1:0] got_q[$];
  int unsigned      ovf_seen = 0;
  bit               rdy_g = 1'b1;

  task automatic model_reset();
    for (int unsigned c = 0; c < COLS; c++) begin
      m_shift[c] = '0;
      m_latch[c] = '0;
      for (int unsigned b = 0; b < NB; b++) begin
        m_acc[c][b]  = 0;
        m_word[c][b] = 0;
      end
    end
    m_lrow = 0; m_wrow = 0; m_left = 0; m_rvalid = 0; m_ovf = 0;
    m_pend = '{'0, 0, 0, 0, 0};
    m_prev = '{'0, 0, 0, 0, 0};
  endtask

  task automatic model_edge(input bit ready);
    sample_t     s = m_pend;
    bit          busy = (m_left != 0);
    int unsigned nxt [COLS][NB];
    m_ovf = 0;
    if (busy && ready) m_left--;
    for (int unsigned c = 0; c < COLS; c++) begin
      for (int unsigned b = 0; b < NB; b++) begin
        nxt[c][b] = m_acc[c][b] + ((s.oe && m_rvalid && m_latch[c][b]) ? 1 : 0);
        if (nxt[c][b] > MAXC) nxt[c][b] = MAXC;
      end
    end
    if (s.lat && !m_prev.lat) begin
      if (m_rvalid && (s.row != m_lrow)) begin
        if (!busy) begin
          m_word = nxt;
          m_wrow = m_lrow;
          m_left = COLS;
        end else begin
          m_ovf = 1;
        end
        for (int unsigned c = 0; c < COLS; c++)
          for (int unsigned b = 0; b < NB; b++) nxt[c][b] = 0;
      end
      m_latch  = m_shift;
      m_lrow   = s.row;
      m_rvalid = 1;
    end
    m_acc = nxt;
    if (s.oclk && !m_prev.oclk) begin
      for (int unsigned c = 0; c + 1 < COLS; c++) m_shift[c] = m_shift[c + 1];
      m_shift[COLS-1] = s.rgb;
    end
    m_prev = s;
  endtask

  function automatic logic [NB*CW-1:0] pack_word(input int unsigned col);
    logic [NB*CW-1:0] v = '0;
    for (int unsigned b = 0; b < NB; b++) v[b*CW +: CW] = CW'(m_word[col][b]);
    return v;
  endfunction

  task automatic compare_outputs();
    int unsigned col;
    check("valid", out_valid, m_left != 0);
    check("overflow", overflow, m_ovf);
    if (overflow) ovf_seen++;
    if (m_left != 0) begin
      col = COLS - m_left;
      check("column", out_column, col);
      check("row", out_row, m_wrow);
      check("count", out_count, pack_word(col));
    end else begin
      check("idle_column", out_column, 0);
    end
  endtask

  task automatic cycle(input bit [NB-1:0] r, input bit ck, input bit lt, input bit o,
                       input int unsigned rw, input bit rdy);
    rgb = r; oclk = ck; lat = lt; oe = o; row = 2'(rw); out_ready = rdy;
    if (out_valid && rdy) got_q.push_back(out_count);
    @(posedge clk);
    model_edge(rdy);
    m_pend = '{r, ck, lt, o, rw};
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b0; rgb = '0; oclk = 0; lat = 0; oe = 0; row = '0; out_ready = 0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_row", out_row, 0);
    check("rst_column", out_column, 0);
    check("rst_count", out_count, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    got_q.delete();
  endtask

  task automatic shift_bit(input bit [NB-1:0] r);
    cycle(r, 1, 0, 0, 0, rdy_g);
    cycle(r, 0, 0, 0, 0, rdy_g);
  endtask

  task automatic latch_row(input int unsigned rw);
    cycle('0, 0, 1, 0, rw, rdy_g);
    cycle('0, 0, 0, 0, rw, rdy_g);
  endtask

  task automatic oe_run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle('0, 0, 0, 1, 0, rdy_g);
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 40 && out_valid; i++) cycle('0, 0, 0, 0, 0, 1'b1);
    check("drain_done", out_valid, 0);
  endtask

  task automatic check_words(input string tag, input logic [NB*CW-1:0] e0, e1, e2, e3);
    logic [NB*CW-1:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({tag, "_nwords"}, got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check(tag, (i < got_q.size()) ? got_q[i] : {NB*CW{1'b1}}, e[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ovf_base;
    @(negedge clk);
    do_reset();

    // Basic row: R pattern 1,0,1,1 lit 5 cycles.
    rdy_g = 1'b1;
    shift_bit(6'b000001); shift_bit(6'b000000); shift_bit(6'b000001); shift_bit(6'b000001);
    latch_row(0); oe_run(5); latch_row(1); drain();
    check_words("basic", 24'h000005, 24'h000000, 24'h000005, 24'h000005);

    // PWM sub-cycles on one row: 3 then 4 oe cycles.
    do_reset();
    shift_bit(6'b000001); shift_bit(6'b000001); shift_bit(6'b000000); shift_bit(6'b000000);
    latch_row(0); oe_run(3);
    shift_bit(6'b000001); shift_bit(6'b000000); shift_bit(6'b000001); shift_bit(6'b000000);
    latch_row(0); oe_run(4); latch_row(1); drain();
    check_words("subcycle", 24'h000007, 24'h000003, 24'h000004, 24'h000000);

    // Saturation at 15 with G seg0 and B seg1 lit for 40 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) shift_bit(6'b100010);
    latch_row(0); oe_run(40); latch_row(1); drain();
    check_words("saturate", 24'hF000F0, 24'hF000F0, 24'hF000F0, 24'hF000F0);

    // Stall at column 1 while another row completes and is dropped.
    do_reset();
    for (int i = 0; i < 4; i++) shift_bit(NB'($urandom));
    latch_row(0); oe_run(6);
    rdy_g = 1'b0;
    latch_row(1);
    cycle('0, 0, 0, 0, 0, 1'b1);
    check("stall_start_col", out_column, 1);
    ovf_base = ovf_seen;
    cycle('0, 0, 0, 0, 0, 0); cycle('0, 0, 0, 0, 0, 0);
    cycle('0, 0, 0, 1, 0, 0); cycle('0, 0, 0, 1, 0, 0); cycle('0, 0, 0, 1, 0, 0);
    cycle('0, 0, 1, 0, 2, 0); cycle('0, 0, 0, 0, 2, 0);
    cycle('0, 0, 0, 0, 0, 0); cycle('0, 0, 0, 0, 0, 0); cycle('0, 0, 0, 0, 0, 0);
    check("stall_col", out_column, 1);
    check("stall_valid", out_valid, 1);
    check("stall_ovf_pulses", ovf_seen - ovf_base, 1);
    rdy_g = 1'b1;
    drain();

    // Reset during column 2 with a row accumulating; no carry-over.
    do_reset();
    for (int i = 0; i < 4; i++) shift_bit(6'b000111);
    latch_row(0); oe_run(3); latch_row(1);
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_column == 2) break;
      cycle('0, 0, 0, 1, 0, 1'b1);
    end
    check("reach_col2", out_column, 2);
    do_reset();
    for (int i = 0; i < 4; i++) shift_bit(6'b001000);
    latch_row(0); oe_run(2); latch_row(3); drain();
    check_words("post_reset", 24'h002000, 24'h002000, 24'h002000, 24'h002000);

    // Same-cycle oclk+lat+oe: latch takes old shift, increment uses old latch.
    do_reset();
    shift_bit(6'b000001); shift_bit(6'b000000); shift_bit(6'b000000); shift_bit(6'b000000);
    latch_row(0);
    shift_bit(6'b000000); shift_bit(6'b000001); shift_bit(6'b000001); shift_bit(6'b000001);
    cycle(6'b000001, 1, 1, 1, 0, 1'b1);
    cycle(6'b000001, 0, 0, 0, 0, 1'b1);
    oe_run(2); latch_row(1); drain();
    check_words("same_cycle", 24'h000001, 24'h000002, 24'h000002, 24'h000002);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle(NB'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom),
            $urandom_range(0, ROWS - 1), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
